pixel_fifo: RTL and testbench
=============================

Name: pixel_fifo

Overview:
Parametrised first-word-fall-through pixel buffer for the video controller. It replaces the three fixed 8-bit/16-deep colour FIFOs with one configurable-width, configurable-depth buffer. Adds a fill-level output, programmable low threshold, sticky error flags with clear, synchronous flush, and a burst refill-request state machine. The state machine drives the controller's memory-read bus requests.

Parameters:
DATA_W, 24, pixel word width (R/G/B packed {R,G,B}).
DEPTH, 16, entries; power of two, 4..1024.
BURST_LEN, 4, beats per refill burst; 1..DEPTH.
AW, $clog2(DEPTH), derived pointer index width (localparam).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe (bus read-data beat)
wr_data  in  DATA_W  write data
rd_en  in  1  pop strobe (pixel clock enable from timing logic)
rd_data  out  DATA_W  head entry; valid when empty=0
full  out  1  level==DEPTH
empty  out  1  level==0
level  out  AW+1  current occupancy 0..DEPTH
thresh  in  AW+1  low-water threshold (from control register)
below_thresh  out  1  level<=thresh
flush  in  1  synchronous discard of all contents
clr_err  in  1  clears sticky flags
overflow  out  1  sticky: write while full
underflow  out  1  sticky: pop while empty
refill_en  in  1  enables refill requests (controller enable bit)
refill_req  out  1  burst request to bus master
refill_ack  in  1  bus accepted request
burst_done  out  1  one-cycle pulse when last burst beat received

Behaviour:
- Reset (async, reset_n=0): pointers=0, level=0, empty=1, full=0, overflow=0, underflow=0, refill_req=0, burst_done=0, FSM=IDLE. Storage is not reset; rd_data is don't-care while empty.
- Pointers are AW+1 bits; full/empty come from MSB compare plus index equality. Wrap at DEPTH is natural via modulo index.
- Write is accepted iff wr_en && !full. The entry is visible on rd_data the next cycle if the FIFO was empty (1-cycle write-to-read latency).
- Pop is accepted iff rd_en && !empty. rd_data advances the next cycle.
- Simultaneous accepted write and pop: level unchanged.
- Write when full: data dropped, overflow set, even if a pop occurs in the same cycle (no pass-through).
- Pop when empty: underflow set. A same-cycle write into an empty FIFO is still accepted.
- Sticky flags: a set in the same cycle as clr_err wins.
- flush (registered, 1 cycle): pointers/level to 0. Writes and pops in the flush cycle are ignored. Sticky flags are unaffected.
- below_thresh, full, empty, level are combinational from registered pointers.
- Refill FSM states: IDLE, REQ, FILL, DISCARD.
  - IDLE -> REQ when refill_en && below_thresh && (DEPTH-level)>=BURST_LEN.
  - REQ: refill_req=1, held until refill_ack. REQ -> FILL on refill_ack. REQ -> IDLE if refill_en drops before ack.
  - FILL: beat counter increments per wr_en. On beat BURST_LEN, pulse burst_done and go to IDLE.
  - The IDLE-entry space check guarantees no overflow from an owned burst.
  - flush during FILL -> DISCARD; flush during REQ -> IDLE.
  - DISCARD: remaining beats are counted but not stored. burst_done pulses on the final beat, then IDLE.
- reset mid-burst: FSM to IDLE immediately; the bus master is responsible for its own abort.

Optional Feature:
PIXEL_FIFO_WATERMARK_EN
- Defined: adds output max_level [AW:0], the peak level since reset or clr_err. clr_err loads the current level. Also adds underrun_cnt [15:0], a saturating count of underflow events, cleared by clr_err.
- Undefined: neither port exists and no extra logic is built.

Decomposition:
- pixel_fifo_pkg: refill_state_e enum {IDLE,REQ,FILL,DISCARD}; default DATA_W/DEPTH/BURST_LEN constants; a pack/unpack function for {R,G,B} bytes.
- One sub-module, pixel_fifo_mem: a simple dual-port array with synchronous write and asynchronous read, parametrised by DATA_W/DEPTH. Pointers, flags and FSM stay in pixel_fifo.

Test Plan (DEPTH=16, BURST_LEN=4, DATA_W=24):
1. Reset, write 0x112233 then 0x445566, pop twice -> rd_data 0x112233 one cycle after the first write, then 0x445566; level 1,2,1,0; empty=1 at end.
2. Write 17 words with no pops -> full=1 at level 16, 17th dropped, overflow=1. Assert clr_err with no write -> overflow=0. Pop all -> data order 0..15, no corruption across pointer wrap.
3. Pop on empty with a simultaneous write of 0xAA0000 -> underflow=1, level=1, rd_data=0xAA0000 the next cycle.
4. thresh=8, refill_en=1, level=0 -> refill_req=1. Ack, then 4 writes -> burst_done pulses on 4th beat, level=4, refill_req reasserts next cycle. At level=13 no request (space 3<4).
5. Ack a burst, 2 beats, then flush -> level=0, FSM DISCARD. Next 2 beats are not stored; burst_done on 2nd; level stays 0.
6. Drop reset_n asynchronously (between clock edges) mid-FILL with level=6 -> outputs at reset values immediately; after release, empty=1 and refill_req rises once refill_en && below_thresh hold.

Source files
------------

// File: rtl/pixel_fifo_pkg.sv
// pixel_fifo_pkg: shared types and defaults for the pixel FIFO slice.
//   refill_state_e : refill request FSM states
//   DEF_*          : default DATA_W / DEPTH / BURST_LEN
//   pack_rgb / rgb_chan : {R,G,B} byte pack / unpack helpers
package pixel_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        FILL    = 2'd2,
        DISCARD = 2'd3
    } refill_state_e;

    localparam int DEF_DATA_W    = 24;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_BURST_LEN = 4;

    function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {r, g, b};
    endfunction

    // idx 0 = B, 1 = G, 2 = R
    function automatic logic [7:0] rgb_chan(input logic [23:0] px,
                                            input int unsigned idx);
        logic [7:0] ch;
        ch = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i == idx) ch = px[8*i +: 8];
        end
        return ch;
    endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// pixel_fifo_mem: simple dual-port storage, synchronous write, asynchronous read.
//   clk     : write clock
//   wr_en   : write strobe, wr_addr/wr_data captured on the rising edge
//   rd_addr : read index, rd_data follows combinationally
// Contents are not reset.
module pixel_fifo_mem
    import pixel_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_fifo.sv
// pixel_fifo: first-word-fall-through pixel buffer with fill level, low-water
// threshold, sticky error flags, synchronous flush and a burst refill FSM.
//   clk, reset_n (async, active low)
//   wr_en/wr_data        : bus read-data beats into the buffer
//   rd_en/rd_data        : pixel pop strobe / head entry (valid when !empty)
//   full, empty, level   : occupancy, combinational from registered pointers
//   thresh/below_thresh  : low-water compare (level <= thresh)
//   flush                : discard all contents this cycle
//   clr_err, overflow, underflow : sticky error flags
//   refill_en/req/ack, burst_done : bus refill handshake
// Optional (define PIXEL_FIFO_WATERMARK_EN): max_level, underrun_cnt.
module pixel_fifo
    import pixel_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BURST_LEN = DEF_BURST_LEN,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    input  logic [AW:0]       thresh,
    output logic              below_thresh,
    input  logic              flush,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow,
    input  logic              refill_en,
    output logic              refill_req,
    input  logic              refill_ack,
    output logic              burst_done
`ifdef PIXEL_FIFO_WATERMARK_EN
    ,
    output logic [AW:0]       max_level,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BURST_V = (AW+1)'(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   space;
    logic          wr_req, wr_acc, rd_acc;
    logic          ovf_set, udf_set;
    refill_state_e state;
    logic [CW-1:0] beat_cnt;

    // ---------------- occupancy ----------------
    always_comb begin
        level        = wr_ptr - rd_ptr;
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        below_thresh = (level <= thresh);
        space        = DEPTH_V - level;
    end

    // Beats arriving while discarding are consumed without being stored,
    // and so also cannot raise overflow.
    always_comb begin
        wr_req  = wr_en && !flush && (state != DISCARD);
        wr_acc  = wr_req && !full;
        ovf_set = wr_req && full;
        rd_acc  = rd_en && !flush && !empty;
        udf_set = rd_en && !flush && empty;
    end

    pixel_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // ---------------- pointers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- sticky flags (set beats clear) ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (udf_set)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

    // ---------------- refill FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            refill_req <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (refill_en && below_thresh && (space >= BURST_V)) begin
                        state      <= REQ;
                        refill_req <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack the bus already gave must still be drained, so an
                    // ack coinciding with flush goes straight to DISCARD.
                    if (refill_ack) begin
                        refill_req <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= flush ? DISCARD : FILL;
                    end else if (flush || !refill_en) begin
                        refill_req <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FILL, DISCARD: begin
                    if (wr_en && (beat_cnt == LAST_BEAT)) begin
                        burst_done <= 1'b1;
                        beat_cnt   <= '0;
                        state      <= IDLE;
                    end else begin
                        if (wr_en) beat_cnt <= beat_cnt + 1'b1;
                        if (flush) state <= DISCARD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIXEL_FIFO_WATERMARK_EN
    // Peak tracks the registered level, so it trails a new maximum by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_level    <= '0;
            underrun_cnt <= '0;
        end else begin
            if (clr_err)                max_level <= level;
            else if (level > max_level) max_level <= level;

            if (udf_set) begin
                if (clr_err)                   underrun_cnt <= 16'd1;
                else if (underrun_cnt != '1)   underrun_cnt <= underrun_cnt + 1'b1;
            end else if (clr_err) begin
                underrun_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
module tb_pixel_fifo;
    import pixel_fifo_pkg::*;

    localparam int DW = 24;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, rd_en, flush, clr_err, refill_en, refill_ack;
    logic [DW-1:0] wr_data, rd_data;
    logic          full, empty, below_thresh, overflow, underflow;
    logic          refill_req, burst_done;
    logic [4:0]    level, thresh;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pixel_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DP),
        .BURST_LEN (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .thresh       (thresh),
        .below_thresh (below_thresh),
        .flush        (flush),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow),
        .refill_en    (refill_en),
        .refill_req   (refill_req),
        .refill_ack   (refill_ack),
        .burst_done   (burst_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Apply one cycle of strobes, then sample 1 time unit after the edge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic fl, input logic clr);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl; clr_err = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic ack_step();
        refill_ack = 1'b1;
        @(posedge clk);
        #1;
        refill_ack = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic [4:0]    lvl;
        logic          emp;
        logic          dchk;
        logic [DW-1:0] dat;
    } vec_t;

    vec_t vt[7];

    logic [DW-1:0] q[$];
    logic          m_ovf, m_udf;

    initial begin
        int wp;
        logic we, re, fl, clr;
        logic [DW-1:0] wd;
        logic got;

        vt[0] = '{1'b1, 24'h112233, 1'b0, 5'd1, 1'b0, 1'b1, 24'h112233};
        vt[1] = '{1'b1, 24'h445566, 1'b0, 5'd2, 1'b0, 1'b1, 24'h112233};
        vt[2] = '{1'b0, 24'h000000, 1'b1, 5'd1, 1'b0, 1'b1, 24'h445566};
        vt[3] = '{1'b0, 24'h000000, 1'b1, 5'd0, 1'b1, 1'b0, 24'h000000};
        vt[4] = '{1'b1, 24'h000001, 1'b0, 5'd1, 1'b0, 1'b1, 24'h000001};
        vt[5] = '{1'b1, 24'h000002, 1'b1, 5'd1, 1'b0, 1'b1, 24'h000002};
        vt[6] = '{1'b0, 24'h000000, 1'b1, 5'd0, 1'b1, 1'b0, 24'h000000};

        reset_n = 1'b0; wr_en = 0; wr_data = '0; rd_en = 0; flush = 0; clr_err = 0;
        refill_en = 0; refill_ack = 0; thresh = 5'd8;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // ---- reset state ----
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_req", refill_req, 0);
        chk("rst_bdone", burst_done, 0);

        // ---- 1: table-driven basic write/pop ----
        for (int i = 0; i < 7; i++) begin
            step(vt[i].we, vt[i].wd, vt[i].re, 1'b0, 1'b0);
            chk($sformatf("vec%0d_level", i), level, vt[i].lvl);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].emp);
            if (vt[i].dchk) chk($sformatf("vec%0d_data", i), rd_data, vt[i].dat);
        end

        // ---- 2: fill past full, clear, drain across pointer wrap ----
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
            if (i == 15) begin
                chk("fill16_full", full, 1);
                chk("fill16_level", level, 16);
                chk("fill16_ovf", overflow, 0);
            end
        end
        chk("fill17_level", level, 16);
        chk("fill17_ovf", overflow, 1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), rd_data, 24'(i));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", empty, 1);
        chk("drain_udf", underflow, 0);

        // ---- 3: pop on empty with same-cycle write ----
        step(1'b1, pack_rgb(8'hAA, 8'h00, 8'h00), 1'b1, 1'b0, 1'b0);
        chk("udf_set", underflow, 1);
        chk("udf_level", level, 1);
        chk("udf_data", rd_data, 24'hAA0000);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("udf_clr", underflow, 0);
        chk("udf_empty", empty, 1);

        // ---- 4: refill request, burst, space boundary ----
        thresh = 5'd8; refill_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("req_rise", refill_req, 1);
        ack_step();
        chk("req_drop_ack", refill_req, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 24'h100 + 24'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("beat%0d_bdone", i), burst_done, (i == 3) ? 1 : 0);
        end
        chk("burst_level", level, 4);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("bdone_pulse", burst_done, 0);
        chk("req_reassert", refill_req, 1);
        refill_en = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("req_abandon", refill_req, 0);
        for (int i = 0; i < 9; i++) step(1'b1, 24'h200 + 24'(i), 1'b0, 1'b0, 1'b0);
        chk("l13_level", level, 13);
        thresh = 5'd15; refill_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("l13_noreq%0d", i), refill_req, 0);
        end
        chk("l13_below", below_thresh, 1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("l12_level", level, 12);
        chk("l12_req_lat", refill_req, 0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("l12_req", refill_req, 1);
        refill_en = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush_level", level, 0);
        chk("flush_req", refill_req, 0);

        // ---- 5: flush mid-burst, remaining beats discarded ----
        thresh = 5'd8; refill_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("d_req", refill_req, 1);
        ack_step();
        step(1'b1, 24'h301, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h302, 1'b0, 1'b0, 1'b0);
        chk("d_level2", level, 2);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("d_flush_level", level, 0);
        chk("d_flush_req", refill_req, 0);
        step(1'b1, 24'h303, 1'b0, 1'b0, 1'b0);
        chk("d_beat3_level", level, 0);
        chk("d_beat3_bdone", burst_done, 0);
        chk("d_beat3_req", refill_req, 0);
        step(1'b1, 24'h304, 1'b0, 1'b0, 1'b0);
        chk("d_beat4_level", level, 0);
        chk("d_beat4_bdone", burst_done, 1);
        chk("d_beat4_ovf", overflow, 0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("d_after_req", refill_req, 1);
        refill_en = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // ---- 6: async reset mid-FILL ----
        for (int i = 0; i < 4; i++) step(1'b1, 24'h400 + 24'(i), 1'b0, 1'b0, 1'b0);
        refill_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("r_req", refill_req, 1);
        ack_step();
        step(1'b1, 24'h410, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h411, 1'b0, 1'b0, 1'b0);
        chk("r_level6", level, 6);
        #2 reset_n = 1'b0;
        #1;
        chk("r_async_level", level, 0);
        chk("r_async_empty", empty, 1);
        chk("r_async_full", full, 0);
        chk("r_async_req", refill_req, 0);
        chk("r_async_bdone", burst_done, 0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clk); #1;
            got = refill_req;
        end
        chk("r_post_empty", empty, 1);
        chk("r_post_req_within_5", got, 1);
        refill_en = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // ---- random: queue model of data path and sticky flags ----
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        chk("rnd_sync_ovf", overflow, 0);
        chk("rnd_sync_udf", underflow, 0);
        for (int c = 0; c < 400; c++) begin
            wp  = (((c / 50) % 2) == 0) ? 75 : 25;
            we  = ($urandom_range(0, 99) < wp);
            re  = ($urandom_range(0, 99) < (100 - wp));
            fl  = ($urandom_range(0, 99) < 2);
            clr = ($urandom_range(0, 99) < 5);
            wd  = 24'($urandom);
            thresh = 5'($urandom_range(0, 16));
            step(we, wd, re, fl, clr);

            if (fl) begin
                q.delete();
                if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
            end else begin
                logic os, us;
                os = we && (q.size() == DP);
                us = re && (q.size() == 0);
                if (re && q.size() > 0) void'(q.pop_front());
                if (we && !os) q.push_back(wd);
                m_ovf = os ? 1'b1 : (clr ? 1'b0 : m_ovf);
                m_udf = us ? 1'b1 : (clr ? 1'b0 : m_udf);
            end

            chk("rnd_level", level, q.size());
            chk("rnd_empty", empty, (q.size() == 0) ? 1 : 0);
            chk("rnd_full", full, (q.size() == DP) ? 1 : 0);
            chk("rnd_below", below_thresh, (q.size() <= int'(thresh)) ? 1 : 0);
            chk("rnd_ovf", overflow, m_ovf);
            chk("rnd_udf", underflow, m_udf);
            if (q.size() > 0) chk("rnd_data", rd_data, q[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
